// File: rtl/mem_layout_pkg.sv
// Shared layout constants for the DAC sample path and the fanout mode encoding
// used by the multi-channel batch distributor.
package mem_layout_pkg;

  localparam int BATCH_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_BROADCAST   = 2'd0,
    MODE_ROUND_ROBIN = 2'd1,
    MODE_SELECT      = 2'd2,
    MODE_RESERVED    = 2'd3
  } fanout_mode_t;

  // The reserved encoding behaves as broadcast, so it is folded away at latch time.
  function automatic fanout_mode_t decode_mode(input logic [1:0] raw);
    return (raw == 2'd3) ? MODE_BROADCAST : fanout_mode_t'(raw);
  endfunction

endpackage

// File: rtl/batch_fifo.sv
// Synchronous first-word-fall-through FIFO for one DAC channel. A push becomes
// visible at the head on the following cycle; flush empties it in one cycle.
module batch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers, and a
  // stale head is never observed because consumers gate it with !o_empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dac_batch_fanout.sv
// Distributes one valid/ready stream of DAC batches to NUM_CH channel FIFOs in
// broadcast, round-robin or select mode, with per-channel underflow counters.
module dac_batch_fanout #(
  parameter int NUM_CH      = 4,
  parameter int BATCH_WIDTH = mem_layout_pkg::BATCH_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          dac_clk,
  input  logic                          dac_rstn,
  input  logic [BATCH_WIDTH-1:0]        batch_in,
  input  logic                          batch_in_valid,
  output logic                          batch_in_ready,
  input  logic [1:0]                    cfg_mode,
  input  logic [NUM_CH-1:0]             cfg_ch_en,
  input  logic [$clog2(NUM_CH)-1:0]     cfg_sel,
  input  logic                          cfg_valid,
  input  logic [NUM_CH-1:0]             dac_rdy,
  output logic [NUM_CH*BATCH_WIDTH-1:0] dac_batch_out,
  output logic [NUM_CH-1:0]             dac_batch_valid,
  output logic [NUM_CH*CNT_W-1:0]       underflow_cnt,
  output logic                          active
);

  import mem_layout_pkg::*;

  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fanout_mode_t            r_mode;
  logic [NUM_CH-1:0]       r_ch_en;
  logic [NUM_CH-1:0]       r_primed;
  logic [SEL_W-1:0]        r_sel;
  logic [SEL_W-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]        r_cnt [NUM_CH];

  logic [NUM_CH-1:0]       w_full;
  logic [NUM_CH-1:0]       w_empty;
  logic [NUM_CH-1:0]       w_push;
  logic [NUM_CH-1:0]       w_pop;
  logic [NUM_CH-1:0]       w_starve;
  logic [NUM_CH-1:0]       w_target;
  logic [NUM_CH-1:0]       w_rr_onehot;
  logic [NUM_CH-1:0]       w_sel_onehot;
  logic [BATCH_WIDTH-1:0]  w_head [NUM_CH];
  logic                    w_ready;
  logic                    w_accept;

  function automatic logic [SEL_W-1:0] lowest_en(input logic [NUM_CH-1:0] en);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Next enabled channel strictly above ptr, wrapping to the lowest enabled one.
  function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] ptr,
                                               input logic [NUM_CH-1:0] en);
    logic [SEL_W-1:0] idx;
    idx = lowest_en(en);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i] && (i > int'(ptr))) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  assign w_rr_onehot  = NUM_CH'(1) << r_rr_ptr;
  assign w_sel_onehot = NUM_CH'(1) << r_sel;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_target = '0;
    case (r_mode)
      MODE_ROUND_ROBIN: w_target = w_rr_onehot & r_ch_en;
      MODE_SELECT:      w_target = w_sel_onehot & r_ch_en;
      default:          w_target = r_ch_en;
    endcase
  end

  // Readiness looks only at registered full; a same-cycle pop does not free a slot.
  assign w_ready  = !cfg_valid && (w_target != '0) && ((w_target & w_full) == '0);
  assign w_accept = batch_in_valid && w_ready;
  assign w_push   = w_accept ? w_target : '0;
  assign w_pop    = r_ch_en & dac_rdy & ~w_empty;
  assign w_starve = r_primed & r_ch_en & dac_rdy & w_empty;

  always_ff @(posedge dac_clk) begin
    if (!dac_rstn) begin
      r_mode   <= MODE_BROADCAST;
      r_ch_en  <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else if (cfg_valid) begin
      r_mode   <= decode_mode(cfg_mode);
      r_ch_en  <= cfg_ch_en;
      r_sel    <= cfg_sel;
      r_rr_ptr <= lowest_en(cfg_ch_en);
    end else if (w_accept && (r_mode == MODE_ROUND_ROBIN)) begin
      r_rr_ptr <= next_en(r_rr_ptr, r_ch_en);
    end
  end

  always_ff @(posedge dac_clk) begin
    if (!dac_rstn || cfg_valid) begin
      r_primed <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_pop[i]) r_primed[i] <= 1'b1;
        if (w_starve[i] && (r_cnt[i] != CNT_MAX)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    batch_fifo #(
      .WIDTH (BATCH_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (dac_clk),
      .i_rst_n (dac_rstn),
      .i_flush (cfg_valid),
      .i_push  (w_push[g]),
      .i_data  (batch_in),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );

    assign dac_batch_out[g*BATCH_WIDTH +: BATCH_WIDTH] = w_pop[g] ? w_head[g] : '0;
    assign underflow_cnt[g*CNT_W +: CNT_W]             = r_cnt[g];
  end

  assign batch_in_ready  = w_ready;
  assign dac_batch_valid = w_pop;
  assign active          = |(r_ch_en & ~w_empty);

endmodule
